// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
// The master side (EX/hazard logic) drives operations and MTHI/MTLO; the slave side returns HI/LO.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wr_data, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wr_data, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO: magnitude shift-add multiply and
// restoring divide on one shared acc/shift register pair, with sign fix-up in a final cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sign_a_s, sign_b_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_sub_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;
  logic [WIDTH-1:0] res_hi_s, res_lo_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      sh_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.cancel) state_d = ST_RUN;
        else                          state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (bus.cancel)           state_d = ST_IDLE;
        else if (cnt_q == '0)     state_d = ST_FIX;
        else                      state_d = ST_RUN;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand conditioning, one iteration step and final sign correction
  always_comb begin
    sign_a_s    = ~bus.op[0] & bus.a[WIDTH-1];
    sign_b_s    = ~bus.op[0] & bus.b[WIDTH-1];
    abs_a_s     = sign_a_s ? neg_w(bus.a) : bus.a;
    abs_b_s     = sign_b_s ? neg_w(bus.b) : bus.b;

    mul_sum_s   = sh_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
    div_shift_s = {acc_q, sh_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    div_sub_s   = div_shift_s[WIDTH-1:0] - opnd_q;

    prod_s      = (sign_a_q ^ sign_b_q) ? neg_2w({acc_q, sh_q}) : {acc_q, sh_q};
    quo_s       = (sign_a_q ^ sign_b_q) ? neg_w(sh_q) : sh_q;
    rem_s       = sign_a_q ? neg_w(acc_q) : acc_q;

    // A zero divisor naturally leaves |a| in the remainder; only LO needs forcing.
    if (is_div_q) begin
      res_hi_s = rem_s;
      res_lo_s = (opnd_q == '0) ? '1 : quo_s;
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Register updates per state
  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    busy_d   = (state_d != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (bus.wr_hi) hi_d = bus.wr_data;
        else           hi_d = hi_q;
        if (bus.wr_lo) lo_d = bus.wr_data;
        else           lo_d = lo_q;
        if (bus.start && !bus.cancel) begin
          cnt_d    = CNT_LAST;
          is_div_d = bus.op[1];
          sign_a_d = sign_a_s;
          sign_b_d = sign_b_s;
          acc_d    = '0;
          sh_d     = bus.op[1] ? abs_a_s : abs_b_s;
          opnd_d   = bus.op[1] ? abs_b_s : abs_a_s;
        end else begin
          cnt_d    = cnt_q;
        end
      end
      ST_RUN: begin
        if (!bus.cancel) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (is_div_q) begin
            acc_d = div_ge_s ? div_sub_s : div_shift_s[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], div_ge_s};
          end else begin
            acc_d = mul_sum_s[WIDTH:1];
            sh_d  = {mul_sum_s[0], sh_q[WIDTH-1:1]};
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_FIX: begin
        if (!bus.cancel) begin
          hi_d   = res_hi_s;
          lo_d   = res_lo_s;
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
